ram_port: RTL

//  CPU-side memory access stage that sits directly upstream of ram.

---
 rtl/ram_port.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/ram_port.sv
// Load/store access stage: one 8..64-bit CPU request -> 1-2 word txs/txe handshakes on the RAM side.
// Latency is set by the synchronised txe edges plus one response cycle; req_ready is high only in IDLE.
module ram_port #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        ram_txs,
    input  logic        ram_txe,
    output logic        ram_re,
    output logic        ram_we,
    output logic [63:0] ram_addr,
    output logic [31:0] ram_wd,
    input  logic [31:0] ram_out,
    input  logic        ram_err
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {S_DRAIN, S_IDLE, S_REQ, S_REL, S_RESP} state_t;

    typedef struct packed {
        logic        re;
        logic        we;
        logic [63:0] addr;
        logic [31:0] wd;
    } cmd_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            2'd2:    return |a[1:0];
            default: return |a;
        endcase
    endfunction

    // Phase 1 of a sub-word store writes back the word read in phase 0 with the addressed bytes replaced.
    function automatic cmd_t phase_cmd(input logic we, input logic [1:0] size, input logic [63:0] addr,
                                       input logic [63:0] wdata, input logic ph, input logic [31:0] rword);
        cmd_t        c;
        logic [31:0] m;
        m = rword;
        if (size == 2'd0) m[{addr[1:0], 3'b000} +: 8]  = wdata[7:0];
        else              m[{addr[1], 4'b0000} +: 16]  = wdata[15:0];
        c.addr = {addr[63:2], 2'b00} + ((ph && size == 2'd3) ? 64'd4 : 64'd0);
        c.re   = !we || (!size[1] && !ph);
        c.we   = !c.re;
        c.wd   = '0;
        if (c.we) begin
            if (!size[1]) c.wd = m;
            else if (ph)  c.wd = wdata[63:32];
            else          c.wd = wdata[31:0];
        end
        return c;
    endfunction

    function automatic logic [63:0] load_result(input logic [1:0] size, input logic sgn, input logic [1:0] a,
                                                input logic [31:0] lo, input logic [31:0] hi);
        logic [7:0]  b;
        logic [15:0] h;
        logic [63:0] r;
        b = lo[{a, 3'b000} +: 8];
        h = lo[{a[1], 4'b0000} +: 16];
        case (size)
            2'd0:    r = sgn ? {{56{b[7]}}, b}  : {56'd0, b};
            2'd1:    r = sgn ? {{48{h[15]}}, h} : {48'd0, h};
            2'd2:    r = sgn ? {{32{lo[31]}}, lo} : {32'd0, lo};
            default: r = {hi, lo};
        endcase
        return r;
    endfunction

    // txe sync resets to all-ones so DRAIN cannot leave before a genuine low level has propagated.
    logic [SYNC_STAGES-1:0] txe_sync_q, err_sync_q;
    logic txe_s, err_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txe_sync_q <= '1;
            err_sync_q <= '0;
        end else begin
            txe_sync_q <= {txe_sync_q[SYNC_STAGES-2:0], ram_txe};
            err_sync_q <= {err_sync_q[SYNC_STAGES-2:0], ram_err};
        end
    end
    assign txe_s = txe_sync_q[SYNC_STAGES-1];
    assign err_s = err_sync_q[SYNC_STAGES-1];

    state_t      state_q;
    logic        ph_q, we_q, sgn_q, err_q;
    logic [1:0]  size_q;
    logic [63:0] addr_q, wdata_q;
    logic [31:0] lo_q, hi_q;
    logic [CW-1:0] tmo_q;
    logic        ready_q, txs_q, re_q, wr_q, rvld_q, rerr_q;
    logic [63:0] raddr_q, rdata_q;
    logic [31:0] wd_q;

    cmd_t        cmd_first, cmd_next;
    logic        more, tmo_hit;
    logic [63:0] ld_res;

    assign cmd_first = phase_cmd(req_we, req_size, req_addr, req_wdata, 1'b0, 32'd0);
    assign cmd_next  = phase_cmd(we_q, size_q, addr_q, wdata_q, 1'b1, lo_q);
    assign more      = !ph_q && (size_q == 2'd3 || (we_q && !size_q[1]));
    assign tmo_hit   = (TIMEOUT != 0) && (tmo_q == CW'(TIMEOUT - 1));
    assign ld_res    = load_result(size_q, sgn_q, addr_q[1:0], lo_q, hi_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_DRAIN;
            ph_q    <= 1'b0;  we_q    <= 1'b0;  sgn_q  <= 1'b0;  err_q <= 1'b0;
            size_q  <= '0;    addr_q  <= '0;    wdata_q <= '0;
            lo_q    <= '0;    hi_q    <= '0;    tmo_q  <= '0;
            ready_q <= 1'b0;  txs_q   <= 1'b0;  re_q   <= 1'b0;  wr_q  <= 1'b0;
            raddr_q <= '0;    wd_q    <= '0;
            rvld_q  <= 1'b0;  rerr_q  <= 1'b0;  rdata_q <= '0;
        end else begin
            rvld_q <= 1'b0;
            case (state_q)
                S_DRAIN: if (!txe_s) begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                S_IDLE: if (req_valid) begin
                    ready_q <= 1'b0;
                    we_q    <= req_we;
                    size_q  <= req_size;
                    sgn_q   <= req_signed;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    ph_q    <= 1'b0;
                    err_q   <= 1'b0;
                    lo_q    <= '0;
                    hi_q    <= '0;
                    tmo_q   <= '0;
                    if (misaligned(req_size, req_addr[2:0])) begin
                        state_q <= S_RESP;
                        rvld_q  <= 1'b1;
                        rerr_q  <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        state_q <= S_REQ;
                        txs_q   <= 1'b1;
                        re_q    <= cmd_first.re;
                        wr_q    <= cmd_first.we;
                        raddr_q <= cmd_first.addr;
                        wd_q    <= cmd_first.wd;
                    end
                end
                S_REQ: if (txe_s || tmo_hit) begin
                    if (txe_s) begin
                        if (ph_q) hi_q <= ram_out;
                        else      lo_q <= ram_out;
                        err_q <= err_q | err_s;
                    end else begin
                        err_q <= 1'b1;
                    end
                    txs_q   <= 1'b0;
                    re_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    tmo_q   <= '0;
                    state_q <= S_REL;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
                S_REL: if (!txe_s) begin
                    tmo_q <= '0;
                    if (more && !err_q) begin
                        ph_q    <= 1'b1;
                        state_q <= S_REQ;
                        txs_q   <= 1'b1;
                        re_q    <= cmd_next.re;
                        wr_q    <= cmd_next.we;
                        raddr_q <= cmd_next.addr;
                        wd_q    <= cmd_next.wd;
                    end else begin
                        state_q <= S_RESP;
                        rvld_q  <= 1'b1;
                        rerr_q  <= err_q;
                        rdata_q <= (err_q || we_q) ? 64'd0 : ld_res;
                    end
                end else if (tmo_hit) begin
                    state_q <= S_RESP;
                    rvld_q  <= 1'b1;
                    rerr_q  <= 1'b1;
                    rdata_q <= '0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    rerr_q  <= 1'b0;
                    rdata_q <= '0;
                end
                default: state_q <= S_DRAIN;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rvld_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rerr_q;
    assign ram_txs   = txs_q;
    assign ram_re    = re_q;
    assign ram_we    = wr_q;
    assign ram_addr  = raddr_q;
    assign ram_wd    = wd_q;
endmodule
